// File: rtl/cam_capture.sv
// Camera capture stage: packs RGB444 byte pairs from a vsync/href framed stream
// into 12-bit frame-buffer writes. Optional macro CAPTURE_DECIM_EN adds 2:1 horizontal decimation.
module cam_capture #(
  parameter int MEM_DEPTH = 153600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_en,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic        cam_valid,
  input  logic [7:0]  cam_data,
  output logic        WriteEn,
  output logic [18:0] WriteAdd,
  output logic [11:0] WriteData,
  output logic        frame_done,
  output logic        overflow,
  output logic        busy
);

  localparam logic [18:0] LAST_ADDR = 19'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

  state_t      state, state_nx;
  logic        vsync_q, href_q;
  logic        phase, phase_nx;
  logic [3:0]  r_lat, r_nx;
  logic [18:0] cnt, cnt_nx;
  logic        full, full_nx;
  logic        ovf_nx;
  logic        we_nx, fd_nx, busy_nx;
  logic [18:0] wa_nx;
  logic [11:0] wd_nx;
  logic        vs_fall, vs_rise, href_fall, byte_ok, keep;
`ifdef CAPTURE_DECIM_EN
  logic        tog, tog_nx;
`endif

  assign vs_fall   = vsync_q & ~cam_vsync;
  assign vs_rise   = ~vsync_q & cam_vsync;
  assign href_fall = href_q & ~cam_href;
  assign byte_ok   = (state == CAPTURE) & cam_valid & cam_href;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    phase_nx = phase;
    r_nx     = r_lat;
    cnt_nx   = cnt;
    full_nx  = full;
    ovf_nx   = overflow;
    we_nx    = 1'b0;
    wa_nx    = WriteAdd;
    wd_nx    = WriteData;
    fd_nx    = 1'b0;
    keep     = 1'b1;
`ifdef CAPTURE_DECIM_EN
    tog_nx   = tog;
`endif
    case (state)
      IDLE: begin
        if (capture_en && cam_vsync) state_nx = ARMED;
      end
      ARMED: begin
        if (!capture_en) state_nx = IDLE;
        else if (vs_fall) begin
          state_nx = CAPTURE;
          cnt_nx   = '0;
          phase_nx = 1'b0;
          ovf_nx   = 1'b0;
          full_nx  = 1'b0;
`ifdef CAPTURE_DECIM_EN
          tog_nx   = 1'b0;
`endif
        end
      end
      CAPTURE: begin
        // realign on line end so an orphan byte never pairs with the next line
        if (href_fall) begin
          phase_nx = 1'b0;
`ifdef CAPTURE_DECIM_EN
          tog_nx   = 1'b0;
`endif
        end
        if (byte_ok) begin
          if (!phase) begin
            r_nx     = cam_data[3:0];
            phase_nx = 1'b1;
          end else begin
            phase_nx = 1'b0;
`ifdef CAPTURE_DECIM_EN
            keep   = ~tog;
            tog_nx = ~tog;
`endif
            if (keep) begin
              if (full) ovf_nx = 1'b1;
              else begin
                we_nx = 1'b1;
                wa_nx = cnt;
                wd_nx = {r_lat, cam_data};
                // counter holds on the last slot; full marks it as consumed
                if (cnt == LAST_ADDR) full_nx = 1'b1;
                else                  cnt_nx  = cnt + 19'd1;
              end
            end
          end
        end
        if (vs_rise) begin
          state_nx = IDLE;
          fd_nx    = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx == CAPTURE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      phase      <= 1'b0;
      r_lat      <= '0;
      cnt        <= '0;
      full       <= 1'b0;
      overflow   <= 1'b0;
      WriteEn    <= 1'b0;
      WriteAdd   <= '0;
      WriteData  <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
`ifdef CAPTURE_DECIM_EN
      tog        <= 1'b0;
`endif
    end else begin
      vsync_q    <= cam_vsync;
      href_q     <= cam_href;
      phase      <= phase_nx;
      r_lat      <= r_nx;
      cnt        <= cnt_nx;
      full       <= full_nx;
      overflow   <= ovf_nx;
      WriteEn    <= we_nx;
      WriteAdd   <= wa_nx;
      WriteData  <= wd_nx;
      frame_done <= fd_nx;
      busy       <= busy_nx;
`ifdef CAPTURE_DECIM_EN
      tog        <= tog_nx;
`endif
    end
  end

endmodule
